// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and types for the radix-2 FFT control path.
//   FFT_N / FFT_LOG2N / FFT_BF_LAT : default transform length, log2 length,
//                                    and butterfly engine latency
//   FFT_AW / FFT_TW                : sample-RAM address and twiddle index widths
//   fft_state_e                    : stage sequencer FSM states
package fft_pkg;

  localparam int unsigned FFT_N      = 16;
  localparam int unsigned FFT_LOG2N  = 4;
  localparam int unsigned FFT_BF_LAT = 2;

  localparam int unsigned FFT_AW = FFT_LOG2N;
  localparam int unsigned FFT_TW = FFT_LOG2N - 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } fft_state_e;

endpackage

// File: rtl/fft_addr_gen.sv
// fft_addr_gen: combinational radix-2 DIT butterfly address generator.
//   stage  in  LOG2N    stage index s
//   k      in  LOG2N-1  butterfly index within the stage
//   addr_a out LOG2N    upper-leg sample address
//   addr_b out LOG2N    lower-leg sample address (addr_a + span)
//   tw_idx out LOG2N-1  twiddle exponent for W_N
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int unsigned LOG2N = FFT_LOG2N
) (
  input  logic [LOG2N-1:0] stage,
  input  logic [LOG2N-2:0] k,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [LOG2N-2:0] tw_idx
);

  localparam int unsigned AW = LOG2N;
  localparam int unsigned TW = LOG2N - 1;

  logic [AW-1:0] k_ext;
  logic [AW-1:0] span;
  logic [AW-1:0] pos;
  logic [AW-1:0] grp;

  always_comb begin
    k_ext  = {1'b0, k};
    span   = AW'(1) << stage;
    pos    = k_ext & (span - AW'(1));
    grp    = k_ext >> stage;
    // Insert a zero at bit position s of k to get the upper leg.
    addr_a = (grp << (stage + AW'(1))) | pos;
    addr_b = addr_a + span;
    tw_idx = TW'(pos << (AW'(LOG2N - 1) - stage));
  end

endmodule

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: control FSM for an in-place radix-2 DIT FFT sharing one
// butterfly engine and one dual-port sample RAM.
//   clk, rst        clock, asynchronous active-high reset
//   new_input_flag  any level change requests a transform
//   rd_en/rd_addr_a/rd_addr_b/tw_idx   butterfly operand fetch
//   wr_en/wr_addr_a/wr_addr_b          write-back, fetch delayed by BF_LAT
//   stage, busy, done, overrun         status (all registered)
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int unsigned N      = FFT_N,
  parameter int unsigned LOG2N  = FFT_LOG2N,
  parameter int unsigned BF_LAT = FFT_BF_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             new_input_flag,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_idx,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b,
  output logic [LOG2N-1:0] stage,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  localparam int unsigned KW = LOG2N - 1;
  localparam int unsigned DW = $clog2(BF_LAT + 1);
  localparam logic [KW-1:0]    K_LAST = KW'(N / 2 - 1);
  localparam logic [DW-1:0]    D_LAST = DW'(BF_LAT - 1);
  localparam logic [LOG2N-1:0] S_LAST = LOG2N'(LOG2N - 1);

  fft_state_e       state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [LOG2N-1:0] stage_q, stage_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic             flag_q;
  logic             start;

  logic             rd_en_q, rd_en_d;
  logic [LOG2N-1:0] rd_addr_a_q, rd_addr_a_d;
  logic [LOG2N-1:0] rd_addr_b_q, rd_addr_b_d;
  logic [KW-1:0]    tw_idx_q, tw_idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;

  logic [BF_LAT-1:0] wr_en_pipe_q, wr_en_pipe_d;
  logic [LOG2N-1:0]  wr_a_pipe_q [BF_LAT];
  logic [LOG2N-1:0]  wr_a_pipe_d [BF_LAT];
  logic [LOG2N-1:0]  wr_b_pipe_q [BF_LAT];
  logic [LOG2N-1:0]  wr_b_pipe_d [BF_LAT];

  logic [LOG2N-1:0] gen_a;
  logic [LOG2N-1:0] gen_b;
  logic [KW-1:0]    gen_tw;

  assign start = new_input_flag ^ flag_q;

  // Addresses are generated from the next (stage,k) so the fetch outputs
  // can be registered without adding a cycle of latency.
  fft_addr_gen #(
    .LOG2N (LOG2N)
  ) u_addr_gen (
    .stage  (stage_d),
    .k      (k_d),
    .addr_a (gen_a),
    .addr_b (gen_b),
    .tw_idx (gen_tw)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    stage_d = stage_q;
    drain_d = drain_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          k_d     = '0;
          stage_d = '0;
        end
      end
      ST_RUN: begin
        if (k_q == K_LAST) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_q == D_LAST) begin
          if (stage_q == S_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            stage_d = stage_q + 1'b1;
            k_d     = '0;
          end
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        stage_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_en_d     = (state_d == ST_RUN);
    rd_addr_a_d = rd_en_d ? gen_a : rd_addr_a_q;
    rd_addr_b_d = rd_en_d ? gen_b : rd_addr_b_q;
    if (rd_en_d)                tw_idx_d = gen_tw;
    else if (state_d == ST_IDLE) tw_idx_d = '0;
    else                        tw_idx_d = tw_idx_q;
    busy_d    = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d    = (state_d == ST_DONE);
    overrun_d = start && (state_q != ST_IDLE);

    wr_en_pipe_d   = {wr_en_pipe_q[BF_LAT-1:0], rd_en_q};
    wr_a_pipe_d[0] = rd_addr_a_q;
    wr_b_pipe_d[0] = rd_addr_b_q;
    for (int unsigned i = 1; i < BF_LAT; i++) begin
      wr_a_pipe_d[i] = wr_a_pipe_q[i-1];
      wr_b_pipe_d[i] = wr_b_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      stage_q      <= '0;
      drain_q      <= '0;
      flag_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_addr_a_q  <= '0;
      rd_addr_b_q  <= '0;
      tw_idx_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
      wr_en_pipe_q <= '0;
      for (int unsigned i = 0; i < BF_LAT; i++) begin
        wr_a_pipe_q[i] <= '0;
        wr_b_pipe_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      stage_q      <= stage_d;
      drain_q      <= drain_d;
      flag_q       <= new_input_flag;
      rd_en_q      <= rd_en_d;
      rd_addr_a_q  <= rd_addr_a_d;
      rd_addr_b_q  <= rd_addr_b_d;
      tw_idx_q     <= tw_idx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
      wr_en_pipe_q <= wr_en_pipe_d;
      for (int unsigned i = 0; i < BF_LAT; i++) begin
        wr_a_pipe_q[i] <= wr_a_pipe_d[i];
        wr_b_pipe_q[i] <= wr_b_pipe_d[i];
      end
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_addr_a = rd_addr_a_q;
  assign rd_addr_b = rd_addr_b_q;
  assign tw_idx    = tw_idx_q;
  assign wr_en     = wr_en_pipe_q[BF_LAT-1];
  assign wr_addr_a = wr_a_pipe_q[BF_LAT-1];
  assign wr_addr_b = wr_b_pipe_q[BF_LAT-1];
  assign stage     = stage_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: scoreboard bench for fft_stage_sequencer (N=16,
// BF_LAT=2). Expected fetches are queued when a run is requested; each
// observed fetch queues its expected write-back BF_LAT cycles later.
module tb_fft_stage_sequencer;

  localparam int N       = 16;
  localparam int LOG2N   = 4;
  localparam int BF_LAT  = 2;
  localparam int RUN_CYC = LOG2N * (N / 2 + BF_LAT);

  typedef struct { int a; int b; int tw; int stage; } rd_exp_t;
  typedef struct { int cyc; int a; int b; } wr_exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             new_input_flag = 1'b0;
  logic             rd_en;
  logic [LOG2N-1:0] rd_addr_a;
  logic [LOG2N-1:0] rd_addr_b;
  logic [LOG2N-2:0] tw_idx;
  logic             wr_en;
  logic [LOG2N-1:0] wr_addr_a;
  logic [LOG2N-1:0] wr_addr_b;
  logic [LOG2N-1:0] stage;
  logic             busy;
  logic             done;
  logic             overrun;

  fft_stage_sequencer #(
    .N      (N),
    .LOG2N  (LOG2N),
    .BF_LAT (BF_LAT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .new_input_flag (new_input_flag),
    .rd_en          (rd_en),
    .rd_addr_a      (rd_addr_a),
    .rd_addr_b      (rd_addr_b),
    .tw_idx         (tw_idx),
    .wr_en          (wr_en),
    .wr_addr_a      (wr_addr_a),
    .wr_addr_b      (wr_addr_b),
    .stage          (stage),
    .busy           (busy),
    .done           (done),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int ovr_cnt  = 0;
  int last_wr_cyc = -100;

  rd_exp_t exp_rd[$];
  wr_exp_t exp_wr[$];
  rd_exp_t mon_e;
  wr_exp_t mon_w;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference ordering: walk groups then positions; k = grp*span + pos.
  task automatic push_run();
    rd_exp_t e;
    for (int s = 0; s < LOG2N; s++) begin
      int span = 1 << s;
      for (int g = 0; g < N / (2 * span); g++) begin
        for (int p = 0; p < span; p++) begin
          e.a     = g * 2 * span + p;
          e.b     = e.a + span;
          e.tw    = p * (N / (2 * span));
          e.stage = s;
          exp_rd.push_back(e);
        end
      end
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      busy_cnt    = 0;
      last_wr_cyc = -100;
    end else begin
      if (rd_en) begin
        if (exp_rd.size() == 0) begin
          check("rd_extra", 1, 0);
        end else begin
          mon_e = exp_rd.pop_front();
          check("rd_a", 32'(rd_addr_a), mon_e.a);
          check("rd_b", 32'(rd_addr_b), mon_e.b);
          check("tw", 32'(tw_idx), mon_e.tw);
          check("stage", 32'(stage), mon_e.stage);
          if (mon_e.stage != 0 && mon_e.a == 0)
            check("stage_gap", cyc, last_wr_cyc + 1);
          mon_w.cyc = cyc + BF_LAT;
          mon_w.a   = mon_e.a;
          mon_w.b   = mon_e.b;
          exp_wr.push_back(mon_w);
        end
      end
      if (wr_en) begin
        if (exp_wr.size() == 0) begin
          check("wr_extra", 1, 0);
        end else begin
          mon_w = exp_wr.pop_front();
          check("wr_cyc", cyc, mon_w.cyc);
          check("wr_a", 32'(wr_addr_a), mon_w.a);
          check("wr_b", 32'(wr_addr_b), mon_w.b);
        end
        last_wr_cyc = cyc;
      end
      if (busy) busy_cnt++;
      if (overrun) ovr_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_len", busy_cnt, RUN_CYC);
        check("done_gap", cyc, last_wr_cyc + 1);
        check("busy_at_done", 32'(busy), 0);
        busy_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int d0, input int limit);
    int i = 0;
    while (done_cnt == d0 && i < limit) begin
      tick();
      i++;
    end
    if (done_cnt == d0) check("done_timeout", 0, 1);
  endtask

  task automatic run_full(input int ovr_at);
    int d0 = done_cnt;
    int o0 = ovr_cnt;
    int t0;
    push_run();
    tick();
    new_input_flag = ~new_input_flag;
    t0 = cyc;
    if (ovr_at > 0) begin
      repeat (ovr_at) tick();
      new_input_flag = ~new_input_flag;
    end
    wait_done(d0, 100);
    check("done_cyc", done_cyc, t0 + RUN_CYC + 1);
    check("done_count", done_cnt, d0 + 1);
    check("ovr_count", ovr_cnt - o0, (ovr_at > 0) ? 1 : 0);
    check("rd_left", exp_rd.size(), 0);
    check("wr_left", exp_wr.size(), 0);
  endtask

  initial begin
    int d0;
    int o0;
    int i;
    rst = 1'b1;
    new_input_flag = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("idle_busy", 32'(busy), 0);
      check("idle_rd", 32'(rd_en), 0);
      check("idle_wr", 32'(wr_en), 0);
      check("idle_done", 32'(done), 0);
    end
    check("idle_stage", 32'(stage), 0);
    check("idle_tw", 32'(tw_idx), 0);

    // Plain run, flag 0->1.
    run_full(0);
    tick();
    check("post_stage", 32'(stage), 0);
    check("post_tw", 32'(tw_idx), 0);

    // Run with a toggle during busy cycle 12: no second run follows.
    run_full(11);
    d0 = done_cnt;
    repeat (10) tick();
    check("no_rerun_busy", 32'(busy), 0);
    check("no_rerun_done", done_cnt, d0);

    // Fresh run on a 1->0 toggle, then toggle exactly while done is high.
    run_full(0);
    o0 = ovr_cnt;
    d0 = done_cnt;
    new_input_flag = ~new_input_flag;
    repeat (10) tick();
    check("done_tgl_ovr", ovr_cnt - o0, 1);
    check("done_tgl_busy", 32'(busy), 0);
    check("done_tgl_done", done_cnt, d0);

    // Reset in the middle of stage 2.
    push_run();
    tick();
    new_input_flag = ~new_input_flag;
    i = 0;
    while (stage != 2 && i < 60) begin
      tick();
      i++;
    end
    check("reach_stage2", 32'(stage), 2);
    repeat (2) tick();
    #2;
    rst = 1'b1;
    #1;
    check("rst_rd", 32'(rd_en), 0);
    check("rst_wr", 32'(wr_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_stage", 32'(stage), 0);
    check("rst_addr", 32'(rd_addr_a), 0);
    exp_rd.delete();
    exp_wr.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("postrst_wr", 32'(wr_en), 0);
      check("postrst_busy", 32'(busy), 0);
    end

    // Full run from stage 0 after the aborted one.
    run_full(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
